// File: rtl/osecpu_result_display.sv
// Purpose: watch OSECPU halt/cycle count, latch DR on halt (or PC on cycle-limit abort), show it in hex on a 4-digit muxed 7-seg.
// Latency: halt sampled at edge N -> done after edge N; seg/segsel are registered one edge behind the digit index and word.
// Backpressure: none; the block only observes CPU status and drives the display every cycle.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   dr[31:0]         OSECPU data register, captured as the result on halt
//   cr[7:0]          OSECPU control register; cr[`BIT_CR_HLT] is the halt flag
//   pc[15:0]         OSECPU program counter, shown live while running and latched on abort
//   seg[7:0]         active-low segments, [0]=a .. [6]=g, [7]=dp
//   segsel[3:0]      active-low one-hot digit select, [0]=rightmost
//   done, timeout    sticky halt-captured / cycle-limit-hit flags

`ifndef BIT_CR_HLT
`define BIT_CR_HLT 0
`endif

module osecpu_result_display #(
  parameter int unsigned CYCLE_LIMIT = 2000,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned PAGE_DIV    = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dr,
  input  logic [7:0]  cr,
  input  logic [15:0] pc,
  output logic [7:0]  seg,
  output logic [3:0]  segsel,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned CYC_W  = (CYCLE_LIMIT > 1) ? $clog2(CYCLE_LIMIT) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned PAGE_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYCLE_LIMIT - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGE_DIV - 1);

  typedef enum logic [1:0] {RUN, HALTED, ABORTED} state_t;

  state_t              state;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [PAGE_W-1:0]   page_cnt;
  logic                page;
  logic [1:0]          dig;
  // Holds DR after a halt, or {16'h0, PC} after an abort; only the low half is shown when aborted.
  logic [31:0]         result;

  logic [15:0]         word;
  logic [3:0]          nib;
  logic                dp_lit;
  logic [7:0]          seg_code;
  logic [3:0]          dig_sel;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'hC0;  4'h1: c = 8'hF9;  4'h2: c = 8'hA4;  4'h3: c = 8'hB0;
      4'h4: c = 8'h99;  4'h5: c = 8'h92;  4'h6: c = 8'h82;  4'h7: c = 8'hF8;
      4'h8: c = 8'h80;  4'h9: c = 8'h90;  4'hA: c = 8'h88;  4'hB: c = 8'h83;
      4'hC: c = 8'hC6;  4'hD: c = 8'hA1;  4'hE: c = 8'h86;  default: c = 8'h8E;
    endcase
    return c;
  endfunction

  // Word, nibble and dp for the digit currently indexed; registered into seg below.
  always_comb begin
    word   = pc;
    dp_lit = 1'b0;
    case (state)
      HALTED: begin
        word   = page ? result[31:16] : result[15:0];
        dp_lit = page && (dig == 2'd3);
      end
      ABORTED: begin
        word   = result[15:0];
        dp_lit = 1'b1;
      end
      default: word = pc;
    endcase
    case (dig)
      2'd0:    begin nib = word[3:0];   dig_sel = 4'b1110; end
      2'd1:    begin nib = word[7:4];   dig_sel = 4'b1101; end
      2'd2:    begin nib = word[11:8];  dig_sel = 4'b1011; end
      default: begin nib = word[15:12]; dig_sel = 4'b0111; end
    endcase
    seg_code = hex7(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      cyc_cnt  <= '0;
      scan_cnt <= '0;
      page_cnt <= '0;
      page     <= 1'b0;
      dig      <= 2'd0;
      result   <= '0;
      seg      <= 8'hFF;
      segsel   <= 4'hF;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      // seg and segsel both come from the same dig value, so they never skew.
      seg    <= {~dp_lit, seg_code[6:0]};
      segsel <= dig_sel;

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        dig      <= dig + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      case (state)
        RUN: begin
          // Halt takes priority over the limit when both land on the same edge.
          if (cr[`BIT_CR_HLT]) begin
            result   <= dr;
            state    <= HALTED;
            done     <= 1'b1;
            page_cnt <= '0;
            page     <= 1'b0;
          end else if (cyc_cnt == CYC_LAST) begin
            result  <= {16'h0000, pc};
            state   <= ABORTED;
            timeout <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        HALTED: begin
          if (page_cnt == PAGE_LAST) begin
            page_cnt <= '0;
            page     <= ~page;
          end else begin
            page_cnt <= page_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osecpu_result_display.sv
`ifndef BIT_CR_HLT
`define BIT_CR_HLT 0
`endif

module tb_osecpu_result_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dr = 32'h0;
  logic [7:0]  cr = 8'h0;
  logic [15:0] pc = 16'h0;
  logic [7:0]  seg;
  logic [3:0]  segsel;
  logic        done;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  osecpu_result_display #(
    .CYCLE_LIMIT(20),
    .SCAN_DIV   (4),
    .PAGE_DIV   (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .dr     (dr),
    .cr     (cr),
    .pc     (pc),
    .seg    (seg),
    .segsel (segsel),
    .done   (done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    int          dig;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] pc_val);
    reset = 1'b1;
    cr    = 8'h00;
    pc    = pc_val;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_hlt(input logic v);
    logic [7:0] c;
    c = 8'h00;
    c[`BIT_CR_HLT] = v;
    cr = c;
  endtask

  // Waits (bounded) for digit d to be selected and returns the segments shown with it.
  task automatic grab(input int d, output logic [7:0] s);
    logic [3:0] tgt;
    bit         found;
    tgt   = 4'b0001 << d;
    tgt   = ~tgt;
    found = 1'b0;
    s     = 8'hXX;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      if (segsel === tgt) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (found) s = seg;
    else begin
      tests++;
      fails++;
      $display("FAIL grab digit %0d: segsel never reached %h", d, tgt);
    end
  endtask

  initial begin
    logic [7:0] s;
    logic [3:0] exp_sel;

    vecs[0]  = '{16'h1234, 0, 8'h99};  vecs[1]  = '{16'h1234, 1, 8'hB0};
    vecs[2]  = '{16'h1234, 2, 8'hA4};  vecs[3]  = '{16'h1234, 3, 8'hF9};
    vecs[4]  = '{16'hABCD, 0, 8'hA1};  vecs[5]  = '{16'hABCD, 1, 8'hC6};
    vecs[6]  = '{16'hABCD, 2, 8'h83};  vecs[7]  = '{16'hABCD, 3, 8'h88};
    vecs[8]  = '{16'h5678, 0, 8'h80};  vecs[9]  = '{16'h5678, 1, 8'hF8};
    vecs[10] = '{16'h5678, 2, 8'h82};  vecs[11] = '{16'h5678, 3, 8'h92};
    vecs[12] = '{16'h0F9E, 0, 8'h86};  vecs[13] = '{16'h0F9E, 1, 8'h90};
    vecs[14] = '{16'h0F9E, 2, 8'h8E};  vecs[15] = '{16'h0F9E, 3, 8'hC0};

    // Reset values and the scan order after release.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset seg", {24'h0, seg}, 32'hFF);
    chk("reset segsel", {28'h0, segsel}, 32'hF);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset timeout", {31'h0, timeout}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_sel = 4'b0001 << ((i / 4) % 4);
      exp_sel = ~exp_sel;
      chk($sformatf("scan order cycle %0d", i + 1), {28'h0, segsel}, {28'h0, exp_sel});
    end

    // Live PC decoding while running.
    for (int v = 0; v < 16; v++) begin
      do_reset(vecs[v].pc);
      grab(vecs[v].dig, s);
      chk($sformatf("run pc=%h dig%0d", vecs[v].pc, vecs[v].dig), {24'h0, s}, {24'h0, vecs[v].exp_seg});
      chk($sformatf("run pc=%h done", vecs[v].pc), {30'h0, done, timeout}, 32'h0);
    end

    // Halt at cycle 10 with two pages of result.
    dr = 32'hFFFF_FFFC;
    do_reset(16'h0000);
    repeat (9) @(negedge clk);
    chk("pre-halt done", {31'h0, done}, 32'h0);
    set_hlt(1'b1);
    @(negedge clk);
    chk("halt done", {31'h0, done}, 32'h1);
    chk("halt timeout", {31'h0, timeout}, 32'h0);
    set_hlt(1'b0);
    dr = 32'h0000_0000;
    pc = 16'h1111;
    grab(0, s); chk("halt page0 dig0", {24'h0, s}, 32'hC6);
    grab(1, s); chk("halt page0 dig1", {24'h0, s}, 32'h8E);
    grab(2, s); chk("halt page0 dig2", {24'h0, s}, 32'h8E);
    grab(3, s); chk("halt page0 dig3", {24'h0, s}, 32'h8E);
    repeat (16) @(negedge clk);
    dr = 32'h1234_5678;
    grab(0, s); chk("halt page1 dig0", {24'h0, s}, 32'h8E);
    grab(1, s); chk("halt page1 dig1", {24'h0, s}, 32'h8E);
    grab(2, s); chk("halt page1 dig2", {24'h0, s}, 32'h8E);
    grab(3, s); chk("halt page1 dig3", {24'h0, s}, 32'h0E);
    chk("halt flags held", {30'h0, done, timeout}, 32'h2);

    // No halt: abort after edge 20 with the latched PC and all dps lit.
    do_reset(16'h0A5F);
    repeat (19) @(negedge clk);
    chk("pre-limit timeout", {31'h0, timeout}, 32'h0);
    @(negedge clk);
    chk("limit timeout", {31'h0, timeout}, 32'h1);
    chk("limit done", {31'h0, done}, 32'h0);
    pc = 16'hFFFF;
    set_hlt(1'b1);
    grab(0, s); chk("abort dig0", {24'h0, s}, 32'h0E);
    grab(1, s); chk("abort dig1", {24'h0, s}, 32'h12);
    grab(2, s); chk("abort dig2", {24'h0, s}, 32'h08);
    grab(3, s); chk("abort dig3", {24'h0, s}, 32'h40);
    chk("abort done stays low", {31'h0, done}, 32'h0);

    // Halt and limit on the same edge: halt wins.
    do_reset(16'h0000);
    repeat (19) @(negedge clk);
    set_hlt(1'b1);
    @(negedge clk);
    chk("tie done", {31'h0, done}, 32'h1);
    chk("tie timeout", {31'h0, timeout}, 32'h0);
    repeat (5) @(negedge clk);
    chk("tie timeout later", {31'h0, timeout}, 32'h0);

    // Reset pulse while halted, then the cycle counter restarts from zero.
    reset = 1'b1;
    set_hlt(1'b0);
    @(negedge clk);
    chk("rst-in-halt seg", {24'h0, seg}, 32'hFF);
    chk("rst-in-halt segsel", {28'h0, segsel}, 32'hF);
    chk("rst-in-halt flags", {30'h0, done, timeout}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst-in-halt first sel", {28'h0, segsel}, 32'hE);
    repeat (18) @(negedge clk);
    chk("restart timeout edge19", {31'h0, timeout}, 32'h0);
    @(negedge clk);
    chk("restart timeout edge20", {31'h0, timeout}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
